ysyx_210247_pipe_buf_stage: RTL and testbench

//  Parametrised inter-stage pipeline buffer; successor to the single-entry stage registers (IF/ID/EXE/MEM/WB).

---
 rtl/ysyx_210247_pipe_buf_pkg.sv | 17 +
 rtl/ysyx_210247_pipe_buf_mem.sv | 28 ++
 rtl/ysyx_210247_pipe_buf_stage.sv | 96 +++++++++
 tb/tb_ysyx_210247_pipe_buf_stage.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_210247_pipe_buf_pkg.sv
// Shared widths and helpers for the inter-stage pipeline buffer.
// The stall counter is enabled with the YSYX_210247_PIPE_STALL_CNT_EN macro in the top.
package ysyx_210247_pipe_buf_pkg;

    // Default payload width for the EXE->MEM boundary.
    localparam int unsigned EXE_TO_MEM_BUS   = 64;
    localparam int unsigned PIPE_BUF_DEPTH   = 2;
    localparam int unsigned PIPE_STALL_CNT_W = 32;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [PIPE_STALL_CNT_W-1:0] sat_inc(
        input logic [PIPE_STALL_CNT_W-1:0] v
    );
        return (&v) ? v : v + PIPE_STALL_CNT_W'(1);
    endfunction

endpackage

// File: rtl/ysyx_210247_pipe_buf_mem.sv
// DEPTH x W storage for the pipeline buffer: one synchronous write port,
// one asynchronous read port. Contents are intentionally not reset.
module ysyx_210247_pipe_buf_mem
    import ysyx_210247_pipe_buf_pkg::*;
#(
    parameter  int unsigned W     = EXE_TO_MEM_BUS,
    parameter  int unsigned DEPTH = PIPE_BUF_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ysyx_210247_pipe_buf_stage.sv
// First-word-fall-through pipeline buffer with registered upstream allow and flush.
// Define YSYX_210247_PIPE_STALL_CNT_EN to build the saturating upstream stall counter.
module ysyx_210247_pipe_buf_stage
    import ysyx_210247_pipe_buf_pkg::*;
#(
    parameter  int unsigned W     = EXE_TO_MEM_BUS,
    parameter  int unsigned DEPTH = PIPE_BUF_DEPTH,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        in_valid,
    input  logic [W-1:0]                in_data,
    output logic                        in_allow,
    output logic                        out_valid,
    output logic [W-1:0]                out_data,
    input  logic                        out_allow,
    output logic [CW-1:0]               count,
    output logic [PIPE_STALL_CNT_W-1:0] stall_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_nxt;
    logic          in_allow_q;
    logic          push;
    logic          pop;
    logic [W-1:0]  rdata;

    assign push      = in_valid & in_allow_q;
    assign pop       = (count_q != '0) & out_allow;
    assign count_nxt = count_q + CW'(push) - CW'(pop);

    // Pointers wrap naturally because DEPTH is a power of two; flush beats push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count_q    <= '0;
            in_allow_q <= 1'b1;
        end else if (flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count_q    <= '0;
            in_allow_q <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q    <= count_nxt;
            in_allow_q <= (count_nxt < CW'(DEPTH));
        end
    end

    ysyx_210247_pipe_buf_mem #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push & ~flush),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    assign in_allow  = in_allow_q;
    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? rdata : '0;
    assign count     = count_q;

`ifdef YSYX_210247_PIPE_STALL_CNT_EN
    logic [PIPE_STALL_CNT_W-1:0] stall_q;

    // Counts cycles where upstream offers a word but the buffer refuses it; flush does not clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (in_valid & ~in_allow_q & ~flush) begin
            stall_q <= sat_inc(stall_q);
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_210247_pipe_buf_stage.sv
// Scoreboard bench for the pipeline buffer: a DEPTH=2 and a DEPTH=4 instance run side by side
// against a queue-based reference model, with directed scenarios followed by random traffic.
module tb_ysyx_210247_pipe_buf_stage;

    localparam int unsigned W    = 8;
    localparam int unsigned DEP0 = 2;
    localparam int unsigned DEP1 = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic out_allow;

    logic           in_valid_w [2];
    logic [W-1:0]   in_data_w  [2];

    logic           ia0, ia1, ov0, ov1;
    logic [W-1:0]   od0, od1;
    logic [1:0]     count0;
    logic [2:0]     count1;
    logic [31:0]    st0, st1;

    int             checks   = 0;
    int             failures = 0;

    logic [W-1:0]   src_words [$];
    int             rd_idx [2];
    int             bubble_pct = 0;
    logic           end_check   = 1'b0;
    logic           end_checked = 1'b0;

    logic [W-1:0]   exp_q [2][$];
    logic           m_allow [2];
    logic [31:0]    m_stall [2];

    always #5 clk = ~clk;

    ysyx_210247_pipe_buf_stage #(.W(W), .DEPTH(DEP0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid_w[0]),
        .in_data   (in_data_w[0]),
        .in_allow  (ia0),
        .out_valid (ov0),
        .out_data  (od0),
        .out_allow (out_allow),
        .count     (count0),
        .stall_cnt (st0)
    );

    ysyx_210247_pipe_buf_stage #(.W(W), .DEPTH(DEP1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid_w[1]),
        .in_data   (in_data_w[1]),
        .in_allow  (ia1),
        .out_valid (ov1),
        .out_data  (od1),
        .out_allow (out_allow),
        .count     (count1),
        .stall_cnt (st1)
    );

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s lane%0d t=%0t act=%0h exp=%0h", nm, g, $time, act, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Upstream producer per lane: walks the shared word list, holding a word until it is taken.
    initial begin : producer
        logic take [2];
        for (int g = 0; g < 2; g++) begin
            in_valid_w[g] = 1'b0;
            in_data_w[g]  = '0;
            rd_idx[g]     = 0;
        end
        forever begin
            @(negedge clk);
            take[0] = in_valid_w[0] && ia0;
            take[1] = in_valid_w[1] && ia1;
            @(posedge clk);
            #1;
            for (int g = 0; g < 2; g++) begin
                if (take[g] || !in_valid_w[g]) begin
                    if (take[g]) rd_idx[g]++;
                    if (rd_idx[g] < src_words.size() && $urandom_range(99) >= 32'(bubble_pct)) begin
                        in_valid_w[g] = 1'b1;
                        in_data_w[g]  = src_words[rd_idx[g]];
                    end else begin
                        in_valid_w[g] = 1'b0;
                        in_data_w[g]  = '0;
                    end
                end
            end
        end
    end

    // Monitor: compare DUT outputs with the model state, then advance the model over the next edge.
    always @(negedge clk) begin : monitor
        logic [31:0]  a_cnt [2];
        logic [31:0]  a_st  [2];
        logic         a_ia  [2];
        logic         a_ov  [2];
        logic [W-1:0] a_od  [2];
        logic [W-1:0] head;
        logic         m_push;
        int           sz;
        int           dep;
        a_cnt[0] = 32'(count0); a_cnt[1] = 32'(count1);
        a_st[0]  = st0;         a_st[1]  = st1;
        a_ia[0]  = ia0;         a_ia[1]  = ia1;
        a_ov[0]  = ov0;         a_ov[1]  = ov1;
        a_od[0]  = od0;         a_od[1]  = od1;
        for (int g = 0; g < 2; g++) begin
            dep = (g == 0) ? int'(DEP0) : int'(DEP1);
            if (!rst_n) begin
                exp_q[g].delete();
                m_allow[g] = 1'b1;
                m_stall[g] = '0;
            end
            sz = exp_q[g].size();
            chk("count",     g, a_cnt[g],         32'(sz));
            chk("in_allow",  g, 32'(a_ia[g]),     32'(m_allow[g]));
            chk("out_valid", g, 32'(a_ov[g]),     32'(sz != 0));
            chk("out_data",  g, 32'(a_od[g]),     (sz != 0) ? 32'(exp_q[g][0]) : 32'd0);
            chk("stall_cnt", g, a_st[g],          m_stall[g]);
            if (end_check && !end_checked) begin
                chk("drained", g, 32'(rd_idx[g]), 32'(src_words.size()));
            end
            if (rst_n) begin
`ifdef YSYX_210247_PIPE_STALL_CNT_EN
                if (in_valid_w[g] && !m_allow[g] && !flush && m_stall[g] != 32'hFFFF_FFFF) begin
                    m_stall[g] = m_stall[g] + 32'd1;
                end
`endif
                if (flush) begin
                    exp_q[g].delete();
                    m_allow[g] = 1'b1;
                end else begin
                    m_push = in_valid_w[g] && m_allow[g];
                    if (exp_q[g].size() != 0 && out_allow) head = exp_q[g].pop_front();
                    if (m_push) exp_q[g].push_back(in_data_w[g]);
                    m_allow[g] = (exp_q[g].size() < dep);
                end
            end
        end
        if (end_check) end_checked = 1'b1;
    end

    initial begin : main
        int n;
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_allow = 1'b1;
        cyc(3);
        rst_n = 1'b1;
        cyc(2);

        // Back-to-back stream with the sink always ready.
        src_words.push_back(8'h11);
        src_words.push_back(8'h22);
        src_words.push_back(8'h33);
        cyc(6);

        // Fill with the sink stalled, then release.
        out_allow = 1'b0;
        for (int i = 0; i < 6; i++) src_words.push_back(8'(8'h41 + i));
        cyc(10);
        out_allow = 1'b1;
        cyc(12);

        // Pointer wrap with the sink toggling every cycle.
        for (int i = 1; i <= 5; i++) src_words.push_back(8'(i));
        for (int i = 0; i < 14; i++) begin
            out_allow = ~out_allow;
            cyc(1);
        end

        // Flush while a word is being offered.
        out_allow = 1'b0;
        for (int i = 0; i < 4; i++) src_words.push_back(8'(8'h51 + i));
        cyc(4);
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        cyc(2);
        out_allow = 1'b1;
        cyc(8);

        // Sustained upstream stall against a full buffer, then flush and drain.
        out_allow = 1'b0;
        for (int i = 0; i < 8; i++) src_words.push_back(8'(8'h61 + i));
        cyc(14);
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        cyc(3);
        out_allow = 1'b1;
        cyc(20);

        // Random traffic with bubbles, backpressure, flushes and two mid-stream resets.
        for (int i = 0; i < 800; i++) src_words.push_back(8'($urandom));
        bubble_pct = 25;
        for (int i = 0; i < 600; i++) begin
            out_allow = ($urandom_range(99) < 60);
            flush     = ($urandom_range(99) < 3);
            if (i == 200 || i == 201 || i == 400) rst_n = 1'b0;
            else rst_n = 1'b1;
            if (i == 200 || i == 400) begin
                // Assert reset mid-cycle so its effect is seen before the next edge.
                #1;
            end
            cyc(1);
        end

        rst_n      = 1'b1;
        flush      = 1'b0;
        out_allow  = 1'b1;
        bubble_pct = 0;
        n = 0;
        while ((rd_idx[0] != src_words.size() || rd_idx[1] != src_words.size() || ov0 || ov1) && n < 1500) begin
            cyc(1);
            n++;
        end
        cyc(2);
        end_check = 1'b1;
        n = 0;
        while (!end_checked && n < 10) begin
            cyc(1);
            n++;
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
